// File: rtl/uart_frame_parser.sv
// Assembles HEAD/CMD/ADDR/DATA_H/DATA_L command frames from a UART byte stream.
// Optional trailing checksum byte enabled by defining FRAME_CHKSUM_EN.
module uart_frame_parser #(
    parameter logic [7:0] HEAD_BYTE   = 8'h55,
    parameter int         TIMEOUT_CYC = 8680,
    parameter int         CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  cmd,
    output logic [7:0]  addr,
    output logic [15:0] data,
    output logic        frame_vld,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

`ifdef FRAME_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_ADDR= 3'd2,
        ST_GET_DH  = 3'd3,
        ST_GET_DL  = 3'd4,
        ST_GET_CHK = 3'd5
    } state_t;

    function automatic logic [7:0] f_sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    logic [7:0] r_sh_dl;
    logic [7:0] r_sum;
    logic       w_chk_err;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_ADDR= 3'd2,
        ST_GET_DH  = 3'd3,
        ST_GET_DL  = 3'd4
    } state_t;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_sh_cmd;
    logic [7:0]       r_sh_addr;
    logic [7:0]       r_sh_dh;
    logic             w_timeout;
    logic             w_complete;

    assign busy = (r_state != ST_IDLE);

    // Next-state decode; a byte strobe always takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
`ifdef FRAME_CHKSUM_EN
        w_chk_err    = 1'b0;
`endif
        w_timeout    = (r_state != ST_IDLE) && !din_vld && (r_cnt == TERM_CNT);
        case (r_state)
            ST_IDLE: begin
                if (din_vld && (din == HEAD_BYTE)) w_next_state = ST_GET_CMD;
                else                               w_next_state = ST_IDLE;
            end
            ST_GET_CMD: begin
                if (din_vld)        w_next_state = ST_GET_ADDR;
                else if (w_timeout) w_next_state = ST_IDLE;
                else                w_next_state = r_state;
            end
            ST_GET_ADDR: begin
                if (din_vld)        w_next_state = ST_GET_DH;
                else if (w_timeout) w_next_state = ST_IDLE;
                else                w_next_state = r_state;
            end
            ST_GET_DH: begin
                if (din_vld)        w_next_state = ST_GET_DL;
                else if (w_timeout) w_next_state = ST_IDLE;
                else                w_next_state = r_state;
            end
            ST_GET_DL: begin
                if (din_vld) begin
`ifdef FRAME_CHKSUM_EN
                    w_next_state = ST_GET_CHK;
`else
                    w_next_state = ST_IDLE;
                    w_complete   = 1'b1;
`endif
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
`ifdef FRAME_CHKSUM_EN
            ST_GET_CHK: begin
                if (din_vld) begin
                    w_next_state = ST_IDLE;
                    if (din == r_sum) w_complete = 1'b1;
                    else              w_chk_err  = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Inter-byte timeout counter: restarts on every byte and whenever idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_cnt <= {CNT_W{1'b0}};
        else if (din_vld || r_state == ST_IDLE) r_cnt <= {CNT_W{1'b0}};
        else                                    r_cnt <= r_cnt + CNT_W'(1);
    end

    // Shadow capture of in-flight frame bytes; never touches the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_cmd  <= 8'h00;
            r_sh_addr <= 8'h00;
            r_sh_dh   <= 8'h00;
`ifdef FRAME_CHKSUM_EN
            r_sh_dl   <= 8'h00;
            r_sum     <= 8'h00;
`endif
        end else if (din_vld) begin
            case (r_state)
                ST_GET_CMD:  r_sh_cmd  <= din;
                ST_GET_ADDR: r_sh_addr <= din;
                ST_GET_DH:   r_sh_dh   <= din;
`ifdef FRAME_CHKSUM_EN
                ST_GET_DL:   r_sh_dl   <= din;
`endif
                default:     r_sh_cmd  <= r_sh_cmd;
            endcase
`ifdef FRAME_CHKSUM_EN
            if (r_state == ST_IDLE)                              r_sum <= 8'h00;
            else if (r_state != ST_GET_CHK)                      r_sum <= f_sum8(r_sum, din);
            else                                                 r_sum <= r_sum;
`endif
        end
    end

    // Registered result outputs and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= 8'h00;
            addr      <= 8'h00;
            data      <= 16'h0000;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_vld <= w_complete;
`ifdef FRAME_CHKSUM_EN
            frame_err <= w_timeout | w_chk_err;
            if (w_chk_err) err_code <= 2'd2;
`else
            frame_err <= w_timeout;
`endif
            if (w_timeout) err_code <= 2'd1;
            if (w_complete) begin
                cmd  <= r_sh_cmd;
                addr <= r_sh_addr;
`ifdef FRAME_CHKSUM_EN
                data <= {r_sh_dh, r_sh_dl};
`else
                data <= {r_sh_dh, din};
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser; follows FRAME_CHKSUM_EN when defined.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int TIMEOUT_CYC = 8680;
`ifdef FRAME_CHKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        frame_vld;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    int last_cyc = 0;
    int v0, e0;

    uart_frame_parser #(.HEAD_BYTE(8'h55), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .cmd(cmd), .addr(addr), .data(data), .frame_vld(frame_vld),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_vld) vld_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (frame_vld && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        last_cyc = cyc;
    endtask

    // frm = {CMD, ADDR, DATA_H, DATA_L, CHK}; CHK only sent when checksum enabled.
    task automatic send_frame(input logic [39:0] frm, input int gap);
        drive_byte(8'h55);
        for (int i = 0; i < NB; i++) begin
            idle(gap);
            drive_byte(frm[39-8*i -: 8]);
        end
    endtask

    initial begin
        // Reset values
        idle(3);
        chk("rst_cmd", {24'h0, cmd}, 32'h0);
        chk("rst_addr", {24'h0, addr}, 32'h0);
        chk("rst_data", {16'h0, data}, 32'h0);
        chk("rst_vld", {31'h0, frame_vld}, 32'h0);
        chk("rst_err", {31'h0, frame_err}, 32'h0);
        chk("rst_code", {30'h0, err_code}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        idle(3);

        // Basic frame with 100-cycle gaps
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h01_10_AB_CD_89, 100);
        chk("a_vld_lat", {31'h0, frame_vld}, 32'h1);
        chk("a_cmd", {24'h0, cmd}, 32'h01);
        chk("a_addr", {24'h0, addr}, 32'h10);
        chk("a_data", {16'h0, data}, 32'hABCD);
        idle(1);
        chk("a_vld_width", {31'h0, frame_vld}, 32'h0);
        chk("a_busy_end", {31'h0, busy}, 32'h0);
        idle(2);
        chk("a_vld_cnt", vld_cnt - v0, 32'd1);
        chk("a_err_cnt", err_cnt - e0, 32'd0);

        // Idle noise then valid frame
        v0 = vld_cnt; e0 = err_cnt;
        drive_byte(8'h00); idle(5);
        drive_byte(8'hFF); idle(5);
        drive_byte(8'h12); idle(5);
        chk("noise_busy", {31'h0, busy}, 32'h0);
        send_frame(40'h02_20_00_01_23, 3);
        idle(3);
        chk("b_cmd", {24'h0, cmd}, 32'h02);
        chk("b_addr", {24'h0, addr}, 32'h20);
        chk("b_data", {16'h0, data}, 32'h0001);
        chk("b_vld_cnt", vld_cnt - v0, 32'd1);
        chk("b_err_cnt", err_cnt - e0, 32'd0);

        // Timeout after 55 03 30
        v0 = vld_cnt; e0 = err_cnt;
        drive_byte(8'h55); idle(2);
        drive_byte(8'h03); idle(2);
        drive_byte(8'h30);
        idle(10);
        chk("to_busy_mid", {31'h0, busy}, 32'h1);
        idle(TIMEOUT_CYC + 10);
        chk("to_err_cnt", err_cnt - e0, 32'd1);
        chk("to_latency", err_cyc - last_cyc, TIMEOUT_CYC);
        chk("to_code", {30'h0, err_code}, 32'd1);
        chk("to_busy", {31'h0, busy}, 32'h0);
        chk("to_cmd_hold", {24'h0, cmd}, 32'h02);
        chk("to_data_hold", {16'h0, data}, 32'h0001);
        chk("to_vld_cnt", vld_cnt - v0, 32'd0);

`ifdef FRAME_CHKSUM_EN
        // Bad checksum then a good frame
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h01_10_AB_CD_00, 2);
        idle(3);
        chk("cs_err_cnt", err_cnt - e0, 32'd1);
        chk("cs_code", {30'h0, err_code}, 32'd2);
        chk("cs_vld_cnt", vld_cnt - v0, 32'd0);
        chk("cs_cmd_hold", {24'h0, cmd}, 32'h02);
        send_frame(40'h07_70_12_34_BD, 2);
        idle(3);
        chk("cs_next_cmd", {24'h0, cmd}, 32'h07);
        chk("cs_next_data", {16'h0, data}, 32'h1234);
        chk("cs_next_vld", vld_cnt - v0, 32'd1);
`endif

        // Back-to-back frames with zero idle gap
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h11_22_33_44_AA, 0);
        chk("bb1_vld", {31'h0, frame_vld}, 32'h1);
        chk("bb1_cmd", {24'h0, cmd}, 32'h11);
        chk("bb1_data", {16'h0, data}, 32'h3344);
        send_frame(40'hA5_5A_12_34_45, 0);
        chk("bb2_vld", {31'h0, frame_vld}, 32'h1);
        chk("bb2_cmd", {24'h0, cmd}, 32'hA5);
        chk("bb2_addr", {24'h0, addr}, 32'h5A);
        chk("bb2_data", {16'h0, data}, 32'h1234);
        idle(3);
        chk("bb_vld_cnt", vld_cnt - v0, 32'd2);
        chk("bb_err_cnt", err_cnt - e0, 32'd0);

        // HEAD value inside a frame is plain data
        send_frame(40'h55_55_55_55_54, 1);
        idle(3);
        chk("hd_cmd", {24'h0, cmd}, 32'h55);
        chk("hd_data", {16'h0, data}, 32'h5555);
        chk("hd_busy", {31'h0, busy}, 32'h0);

        // Byte arriving on the terminal-count cycle wins over the timeout
        v0 = vld_cnt; e0 = err_cnt;
        drive_byte(8'h55);
        drive_byte(8'h09);
        drive_byte(8'h90);
        drive_byte(8'h5A);
        idle(TIMEOUT_CYC - 1);
        drive_byte(8'hA5);
`ifdef FRAME_CHKSUM_EN
        drive_byte(8'h98);
`endif
        idle(3);
        chk("tc_err_cnt", err_cnt - e0, 32'd0);
        chk("tc_vld_cnt", vld_cnt - v0, 32'd1);
        chk("tc_data", {16'h0, data}, 32'h5AA5);

        // Reset mid-frame
        v0 = vld_cnt; e0 = err_cnt;
        drive_byte(8'h55); idle(2);
        drive_byte(8'h04); idle(2);
        chk("mr_busy_pre", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", {31'h0, busy}, 32'h0);
        chk("mr_cmd", {24'h0, cmd}, 32'h0);
        chk("mr_data", {16'h0, data}, 32'h0);
        chk("mr_code", {30'h0, err_code}, 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("mr_no_pulse", (vld_cnt - v0) + (err_cnt - e0), 32'd0);
        send_frame(40'h06_60_BE_EF_13, 1);
        idle(3);
        chk("mr_cmd_after", {24'h0, cmd}, 32'h06);
        chk("mr_addr_after", {24'h0, addr}, 32'h60);
        chk("mr_data_after", {16'h0, data}, 32'hBEEF);
        chk("mr_vld_after", vld_cnt - v0, 32'd1);

        chk("never_both", both_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
